mem_port_arbiter: RTL

- Shares the single unified memory port of the multicycle MIPS core between the instruction-fetch requester and the load/store requester.
- Registers each granted transaction and drives it onto the memory port until the memory acknowledges it.
- Returns read data and a one-cycle done pulse to the winning requester.
- Enforces an acknowledge timeout so a dead memory cannot hang the control FSM.

---
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and load/store, holds the
// granted transaction on m_* until acknowledge or timeout, and returns data plus done.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int TIMEOUT = 16,
    parameter bit PRIO_RR = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic [31:0]   i_rdata,
    output logic          i_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_be,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic [31:0]   d_rdata,
    output logic          d_done,
    output logic          d_err,
    output logic          m_req,
    output logic          m_we,
    output logic [3:0]    m_be,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    input  logic [31:0]   m_rdata,
    input  logic          m_ack,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;

    localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_t        r_state;
    logic          r_last_d;
    logic [CW-1:0] r_cnt;
    logic          r_m_req;
    logic          r_m_we;
    logic [3:0]    r_m_be;
    logic [AW-1:0] r_m_addr;
    logic [31:0]   r_m_wdata;
    logic          r_i_gnt;
    logic          r_d_gnt;
    logic          r_i_done;
    logic          r_d_done;
    logic          r_d_err;
    logic [31:0]   r_i_rdata;
    logic [31:0]   r_d_rdata;
    logic          r_busy;

    // A requester whose done is showing is withdrawing, so it may not win this edge.
    logic w_i_elig;
    logic w_d_elig;
    logic w_pick_d;
    logic w_pick_i;
    logic w_timeout;

    assign w_i_elig  = i_req && !r_i_done;
    assign w_d_elig  = d_req && !r_d_done;
    assign w_pick_d  = w_d_elig && !(w_i_elig && PRIO_RR && r_last_d);
    assign w_pick_i  = w_i_elig && !w_pick_d;
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    // NOTE: all state below is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_last_d  <= 1'b0;
            r_cnt     <= '0;
            r_m_req   <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_be    <= '0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_i_gnt   <= 1'b0;
            r_d_gnt   <= 1'b0;
            r_i_done  <= 1'b0;
            r_d_done  <= 1'b0;
            r_d_err   <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_i_gnt  <= 1'b0;
            r_d_gnt  <= 1'b0;
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
            r_d_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_pick_d) begin
                        r_state   <= BUSY_D;
                        r_busy    <= 1'b1;
                        r_m_req   <= 1'b1;
                        r_m_we    <= d_we;
                        r_m_be    <= d_be;
                        r_m_addr  <= d_addr;
                        r_m_wdata <= d_wdata;
                        r_d_gnt   <= 1'b1;
                        r_last_d  <= 1'b1;
                    end else if (w_pick_i) begin
                        r_state   <= BUSY_I;
                        r_busy    <= 1'b1;
                        r_m_req   <= 1'b1;
                        r_m_we    <= 1'b0;
                        r_m_be    <= 4'b1111;
                        r_m_addr  <= i_addr;
                        r_m_wdata <= '0;
                        r_i_gnt   <= 1'b1;
                        r_last_d  <= 1'b0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    // An ack on the timeout edge still completes normally.
                    if (m_ack || w_timeout) begin
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_m_req   <= 1'b0;
                        r_m_we    <= 1'b0;
                        r_m_be    <= '0;
                        r_m_addr  <= '0;
                        r_m_wdata <= '0;
                        r_d_err   <= !m_ack;
                        if (r_state == BUSY_I) begin
                            r_i_done <= 1'b1;
                            if (m_ack) r_i_rdata <= m_rdata;
                        end else begin
                            r_d_done <= 1'b1;
                            if (m_ack && !r_m_we) r_d_rdata <= m_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign i_gnt   = r_i_gnt;
    assign i_rdata = r_i_rdata;
    assign i_done  = r_i_done;
    assign d_gnt   = r_d_gnt;
    assign d_rdata = r_d_rdata;
    assign d_done  = r_d_done;
    assign d_err   = r_d_err;
    assign m_req   = r_m_req;
    assign m_we    = r_m_we;
    assign m_be    = r_m_be;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign busy    = r_busy;

endmodule
